spi_text_tx: RTL and testbench

- SPI master transmitter, the sending end of the character link whose bytes the text-mode display ingests into text RAM.
- Buffers ASCII bytes from a local producer (test pattern generator, soft-core, loopback host) in a small FIFO.
- Serialises each byte as an SPI mode 0, MSB-first frame with one chip-select window per byte, so the receiver's byte-done edge fires exactly once per character.

---
 rtl/spi_text_tx_if.sv | 37 +++
 rtl/spi_text_tx.sv | 130 +++++++++++++
 tb/tb_spi_text_tx.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_text_tx_if.sv
// spi_text_tx_if
//   Bundles the producer byte handshake and the SPI pins of spi_text_tx.
//   slave  : the transmitter's view (takes bytes, drives SPI and status).
//   master : the producer / observer view.
//   Signals:
//     tx_data[7:0]  byte to send
//     tx_valid      producer offers tx_data
//     tx_ready      FIFO can accept (push on tx_valid && tx_ready)
//     sclk          SPI clock, idles low
//     mosi          SPI data, MSB first
//     cs_n          SPI chip select, active-low, one window per byte
//     busy          FSM active or FIFO non-empty
//     fifo_level    FIFO occupancy
interface spi_text_tx_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic          busy;
  logic [LW-1:0] fifo_level;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sclk, mosi, cs_n, busy, fifo_level
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sclk, mosi, cs_n, busy, fifo_level
  );
endinterface

// File: rtl/spi_text_tx.sv
// spi_text_tx
//   SPI master transmitter for the text-display character link. Bytes from a
//   local producer are buffered in a FIFO and sent as SPI mode 0, MSB-first
//   frames, one cs_n window per byte. All outputs are registered.
//   Ports:
//     clk    core clock
//     rst_n  asynchronous active-low reset
//     bus    spi_text_tx_if.slave (tx_data/tx_valid/tx_ready handshake,
//            sclk/mosi/cs_n pins, busy, fifo_level)
//   Parameters:
//     CLK_DIV     SCLK half-period in clk cycles (2..255)
//     CS_GAP      clk cycles cs_n stays high between frames (1..255)
//     FIFO_DEPTH  FIFO entries, power of two (2..256)
module spi_text_tx #(
  parameter int CLK_DIV    = 8,
  parameter int CS_GAP     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_text_tx_if.slave bus
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              LW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]      DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]      GAP_LOAD = 8'(CS_GAP - 1);
  localparam logic [LW-1:0]   FULL     = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t        r_state, w_state_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          r_ready;
  logic          w_push, w_pop;

  logic [7:0]    r_div, w_div_nxt;
  logic          w_div_done;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic          r_sclk, r_cs_n, r_busy;
  logic          w_sclk_nxt, w_cs_n_nxt, w_busy_nxt;

  assign w_push     = bus.tx_valid && r_ready;
  // Pop looks at the registered level, so a byte pushed into an empty FIFO
  // is taken one cycle later at the earliest.
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
  assign w_div_done = (r_div == '0);

  always_comb begin
    w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tx_data;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != FULL);
      r_sclk  <= w_sclk_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_busy  <= w_busy_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_shift  <= r_mem[r_rd_ptr];
        r_bit    <= 3'd7;
      end else if ((r_state == S_HIGH) && (w_state_nxt == S_LOW)) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_bit   <= r_bit - 3'd1;
      end
    end
  end

  // Next-state logic; every timed state leaves when the divider reaches 0.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_level != '0) w_state_nxt = S_SETUP;
      S_SETUP: if (w_div_done)    w_state_nxt = S_HIGH;
      S_HIGH:  if (w_div_done)    w_state_nxt = (r_bit == '0) ? S_HOLD : S_LOW;
      S_LOW:   if (w_div_done)    w_state_nxt = S_HIGH;
      S_HOLD:  if (w_div_done)    w_state_nxt = S_GAP;
      S_GAP:   if (w_div_done)    w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: pins are decoded from the next state and registered, so
  // each pin changes on the same edge as the state it belongs to.
  always_comb begin
    w_sclk_nxt = (w_state_nxt == S_HIGH);
    w_cs_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
    w_div_nxt  = r_div;
    if (w_state_nxt != r_state)
      w_div_nxt = (w_state_nxt == S_GAP) ? GAP_LOAD : DIV_LOAD;
    else if (!w_div_done)
      w_div_nxt = r_div - 8'd1;
  end

  assign bus.tx_ready   = r_ready;
  assign bus.sclk       = r_sclk;
  assign bus.cs_n       = r_cs_n;
  assign bus.mosi       = r_shift[7];
  assign bus.busy       = r_busy;
  assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_spi_text_tx.sv
// tb_spi_text_tx
//   Two instances share one clock: u0 with default timing (8/8), u1 with the
//   corner timing (CLK_DIV=2, CS_GAP=1). A timing reference computes every
//   output from the frame start cycle with arithmetic; a pin-level decoder
//   rebuilds bytes from sclk/mosi/cs_n.
module tb_spi_text_tx;
  localparam int DEPTH = 16;
  localparam int D0 = 8, G0 = 8, D1 = 2, G1 = 1;

  logic clk;
  logic rst_n0, rst_n1;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  spi_text_tx_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
  spi_text_tx_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

  spi_text_tx #(.CLK_DIV(D0), .CS_GAP(G0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n0), .bus(bus0));
  spi_text_tx #(.CLK_DIV(D1), .CS_GAP(G1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n1), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus
  logic       s_valid [2];
  logic [7:0] s_data  [2];

  // reference model
  int         m_level [2];
  logic       m_ready [2];
  int         m_start [2];
  int         m_free  [2];
  logic [7:0] m_cur   [2];
  bit         m_fresh [2];
  bit         m_rst   [2];
  bit         m_push  [2];
  int         n_push  [2];
  logic [7:0] m_q0[$];
  logic [7:0] m_q1[$];

  // pin decoder
  logic       p_sclk [2];
  logic       p_cs   [2];
  int         f_edges [2];
  int         f_low   [2];
  logic [7:0] f_sh    [2];
  int         f_count [2];
  logic [7:0] f_last  [2];
  int         f_last_low [2];
  int         f_last_edges [2];
  int         f_rises [2];
  int         f_last_rise [2];
  int         f_period [2];
  int         f_starts0[$];
  int         f_starts1[$];
  logic [7:0] f_bytes0[$];
  logic [7:0] f_bytes1[$];

  typedef struct {
    int         unit;
    logic [7:0] data;
    logic [7:0] exp_byte;
    int         exp_low;
    int         exp_edges;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {sclk, cs_n, mosi, tx_ready, busy, fifo_level[4:0]}
  function automatic logic [9:0] dut_out(input int u);
    if (u == 0)
      return {bus0.sclk, bus0.cs_n, bus0.mosi, bus0.tx_ready, bus0.busy, bus0.fifo_level};
    return {bus1.sclk, bus1.cs_n, bus1.mosi, bus1.tx_ready, bus1.busy, bus1.fifo_level};
  endfunction

  task automatic model_edge(input int u);
    logic rst, push, pop;
    int   d, g;
    d = (u == 0) ? D0 : D1;
    g = (u == 0) ? G0 : G1;
    rst = (u == 0) ? rst_n0 : rst_n1;
    m_push[u] = 1'b0;
    if (!rst) begin
      m_level[u] = 0;
      m_ready[u] = 1'b0;
      m_start[u] = -1000000;
      m_free[u]  = 0;
      m_fresh[u] = 1'b1;
      m_rst[u]   = 1'b1;
      if (u == 0) m_q0.delete(); else m_q1.delete();
    end else begin
      push = s_valid[u] && m_ready[u];
      pop  = (cyc >= m_free[u]) && (m_level[u] > 0);
      if (pop) begin
        if (u == 0) m_cur[u] = m_q0.pop_front(); else m_cur[u] = m_q1.pop_front();
        m_start[u] = cyc;
        m_free[u]  = cyc + 17 * d + g + 1;
        m_fresh[u] = 1'b0;
      end
      if (push) begin
        if (u == 0) m_q0.push_back(s_data[u]); else m_q1.push_back(s_data[u]);
        n_push[u]++;
      end
      m_level[u] = m_level[u] + int'(push) - int'(pop);
      m_ready[u] = (m_level[u] != DEPTH);
      m_rst[u]   = 1'b0;
      m_push[u]  = push;
    end
  endtask

  task automatic model_check(input int u);
    int d, j, idx;
    logic [9:0] exp, msk, got;
    d = (u == 0) ? D0 : D1;
    j = cyc - m_start[u];
    msk = '1;
    exp[9] = (j >= d) && (j < 16 * d) && (((j / d) % 2) == 1);
    exp[8] = !((j >= 0) && (j < 17 * d));
    if (m_fresh[u]) exp[7] = 1'b0;
    else if (!exp[8]) begin
      idx = j / (2 * d);
      if (idx > 7) idx = 7;
      exp[7] = m_cur[u][7 - idx];
    end else begin
      exp[7] = 1'b0;
      msk[7] = 1'b0;
    end
    exp[6]   = m_ready[u];
    exp[5]   = (cyc < m_free[u] - 1) || (m_level[u] != 0);
    exp[4:0] = 5'(m_level[u]);
    got = dut_out(u);
    check($sformatf("u%0d outputs cyc %0d", u, cyc), 32'(got & msk), 32'(exp & msk));
  endtask

  task automatic monitor(input int u);
    logic [9:0] o;
    logic sclk, cs, mosi;
    o = dut_out(u);
    sclk = o[9]; cs = o[8]; mosi = o[7];
    if (m_rst[u]) begin
      p_sclk[u] = 1'b0;
      p_cs[u]   = 1'b1;
      return;
    end
    if (!p_sclk[u] && sclk) f_rises[u]++;
    if (p_cs[u] && !cs) begin
      f_edges[u] = 0;
      f_low[u]   = 0;
      f_sh[u]    = '0;
      if (u == 0) f_starts0.push_back(cyc); else f_starts1.push_back(cyc);
    end
    if (!cs) begin
      f_low[u]++;
      if (!p_sclk[u] && sclk) begin
        f_edges[u]++;
        f_sh[u] = {f_sh[u][6:0], mosi};
        if (f_edges[u] > 1) f_period[u] = cyc - f_last_rise[u];
        f_last_rise[u] = cyc;
      end
    end
    if (!p_cs[u] && cs) begin
      f_count[u]++;
      f_last[u]       = f_sh[u];
      f_last_low[u]   = f_low[u];
      f_last_edges[u] = f_edges[u];
      if (u == 0) f_bytes0.push_back(f_sh[u]); else f_bytes1.push_back(f_sh[u]);
      check($sformatf("u%0d frame byte", u), 32'(f_sh[u]), 32'(m_cur[u]));
    end
    p_sclk[u] = sclk;
    p_cs[u]   = cs;
  endtask

  task automatic tick();
    bus0.tx_valid = s_valid[0];
    bus0.tx_data  = s_data[0];
    bus1.tx_valid = s_valid[1];
    bus1.tx_data  = s_data[1];
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    model_check(0);
    model_check(1);
    monitor(0);
    monitor(1);
  endtask

  task automatic wait_idle(input int u, input int bound);
    logic [9:0] o;
    bit done;
    done = 1'b0;
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      o = dut_out(u);
      if (!o[5] && o[8] && (o[4:0] == 5'd0)) done = 1'b1;
    end
    check($sformatf("u%0d idle within %0d", u, bound), 32'(done), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [9:0] o;
    int base, sz, peak, mpeak, acc, saved_cnt, saved_rises, pct0, pct1;
    int pcts [3];
    bit saw_full, found;
    logic [7:0] hi [3];
    logic [7:0] corner [3];

    tbl[0] = '{0, 8'h41, 8'b0100_0001, 136, 8};
    tbl[1] = '{0, 8'h00, 8'b0000_0000, 136, 8};
    tbl[2] = '{0, 8'hFF, 8'b1111_1111, 136, 8};
    tbl[3] = '{1, 8'h00, 8'b0000_0000, 34, 8};
    tbl[4] = '{1, 8'hFF, 8'b1111_1111, 34, 8};
    tbl[5] = '{1, 8'hA5, 8'b1010_0101, 34, 8};
    hi     = '{8'h48, 8'h49, 8'h21};
    corner = '{8'h00, 8'hFF, 8'hA5};
    pcts   = '{3, 15, 70};

    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0; s_data[u] = '0;
      m_level[u] = 0; m_ready[u] = 1'b0; m_start[u] = -1000000; m_free[u] = 0;
      m_cur[u] = '0; m_fresh[u] = 1'b1; m_rst[u] = 1'b1; m_push[u] = 1'b0; n_push[u] = 0;
      p_sclk[u] = 1'b0; p_cs[u] = 1'b1; f_edges[u] = 0; f_low[u] = 0; f_sh[u] = '0;
      f_count[u] = 0; f_last[u] = '0; f_last_low[u] = 0; f_last_edges[u] = 0;
      f_rises[u] = 0; f_last_rise[u] = 0; f_period[u] = 0;
    end
    bus0.tx_valid = 1'b0; bus0.tx_data = '0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0;

    // reset takes effect with no clock edge
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    #1;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    #1;
    check("u0 async reset outs", 32'(dut_out(0)), 32'(10'b0_1_0_0_0_00000));
    check("u1 async reset outs", 32'(dut_out(1)), 32'(10'b0_1_0_0_0_00000));
    for (int i = 0; i < 4; i++) tick();
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // idle after reset
    for (int i = 0; i < 100; i++) tick();
    check("u0 idle outs", 32'(dut_out(0)), 32'(10'b0_1_0_1_0_00000));

    // single-byte frames
    for (int t = 0; t < 6; t++) begin
      base = f_count[tbl[t].unit];
      s_valid[tbl[t].unit] = 1'b1;
      s_data[tbl[t].unit]  = tbl[t].data;
      tick();
      wait_idle(tbl[t].unit, 400);
      check($sformatf("vec%0d frames", t), 32'(f_count[tbl[t].unit] - base), 32'd1);
      check($sformatf("vec%0d byte", t), 32'(f_last[tbl[t].unit]), 32'(tbl[t].exp_byte));
      check($sformatf("vec%0d cs low", t), 32'(f_last_low[tbl[t].unit]), 32'(tbl[t].exp_low));
      check($sformatf("vec%0d edges", t), 32'(f_last_edges[tbl[t].unit]), 32'(tbl[t].exp_edges));
    end
    check("u1 sclk period", 32'(f_period[1]), 32'd4);

    // "HI!" back to back on u0
    peak = 0; mpeak = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid[0] = (i < 3);
      s_data[0]  = hi[i % 3];
      tick();
      o = dut_out(0);
      if (int'(o[4:0]) > peak) peak = int'(o[4:0]);
      if (m_level[0] > mpeak) mpeak = m_level[0];
    end
    wait_idle(0, 600);
    check("HI fifo peak", 32'(peak), 32'(mpeak));
    sz = f_starts0.size();
    check("HI spacing 1", 32'(f_starts0[sz-2] - f_starts0[sz-3]), 32'd145);
    check("HI spacing 2", 32'(f_starts0[sz-1] - f_starts0[sz-2]), 32'd145);
    sz = f_bytes0.size();
    for (int i = 0; i < 3; i++)
      check($sformatf("HI byte %0d", i), 32'(f_bytes0[sz-3+i]), 32'(hi[i]));

    // corner instance back to back
    for (int i = 0; i < 3; i++) begin
      s_valid[1] = 1'b1;
      s_data[1]  = corner[i];
      tick();
    end
    wait_idle(1, 300);
    sz = f_starts1.size();
    check("corner spacing 1", 32'(f_starts1[sz-2] - f_starts1[sz-3]), 32'd36);
    check("corner spacing 2", 32'(f_starts1[sz-1] - f_starts1[sz-2]), 32'd36);
    sz = f_bytes1.size();
    for (int i = 0; i < 3; i++)
      check($sformatf("corner byte %0d", i), 32'(f_bytes1[sz-3+i]), 32'(corner[i]));

    // fill past FIFO depth
    acc = 0; saw_full = 1'b0;
    for (int t = 0; t < 5000 && acc < 20; t++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 8'(8'h30 + acc);
      tick();
      if (m_push[0]) acc++;
      o = dut_out(0);
      if ((o[4:0] == 5'd16) && !o[6]) saw_full = 1'b1;
    end
    check("fill accepted", 32'(acc), 32'd20);
    check("fill saw full+not ready", 32'(saw_full), 32'd1);
    wait_idle(0, 3500);
    sz = f_bytes0.size();
    for (int i = 0; i < 20; i++)
      check($sformatf("fill byte %0d", i), 32'(f_bytes0[sz-20+i]), 32'(8'(8'h30 + i)));

    // reset in the middle of an 8'hFF frame with bytes still queued
    for (int i = 0; i < 3; i++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = (i == 0) ? 8'hFF : 8'(8'hA0 + i);
      tick();
    end
    s_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!dut_out(0)[8]) found = 1'b1;
      else tick();
    end
    check("midreset frame started", 32'(found), 32'd1);
    for (int i = 0; i < 40; i++) tick();
    saved_cnt = f_count[0];
    #2;
    rst_n0 = 1'b0;
    #1;
    check("midreset async outs", 32'(dut_out(0)), 32'(10'b0_1_0_0_0_00000));
    for (int i = 0; i < 3; i++) tick();
    rst_n0 = 1'b1;
    saved_rises = f_rises[0];
    for (int i = 0; i < 300; i++) tick();
    check("midreset no sclk", 32'(f_rises[0] - saved_rises), 32'd0);
    check("midreset no frame", 32'(f_count[0] - saved_cnt), 32'd0);
    check("midreset level", 32'(dut_out(0)[4:0]), 32'd0);

    // randomized traffic on both instances
    base = f_count[0];
    sz   = f_count[1];
    acc  = n_push[0];
    peak = n_push[1];
    pct0 = 3; pct1 = 3;
    for (int t = 0; t < 3000; t++) begin
      if (t % 200 == 0) begin
        pct0 = pcts[$urandom_range(0, 2)];
        pct1 = pcts[$urandom_range(0, 2)];
      end
      s_valid[0] = ($urandom_range(0, 99) < pct0);
      s_valid[1] = ($urandom_range(0, 99) < pct1);
      s_data[0]  = 8'($urandom);
      s_data[1]  = 8'($urandom);
      tick();
    end
    wait_idle(0, 3000);
    wait_idle(1, 1000);
    check("rand u0 frames", 32'(f_count[0] - base), 32'(n_push[0] - acc));
    check("rand u1 frames", 32'(f_count[1] - sz), 32'(n_push[1] - peak));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
